reg_bank: RTL and testbench

//  Parametrised general-purpose register bank for the bus datapath; replaces discrete per-register

---
 rtl/reg_bank_pkg.sv | 12 +
 rtl/reg_bank_rdport.sv | 34 +++
 rtl/reg_bank.sv | 79 +++++++
 tb/tb_reg_bank.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared constants and helpers for the general-purpose register bank.
package reg_bank_pkg;

  localparam int RB_MAX_REGS   = 64;
  localparam int RB_PAIR_ALIGN = 2;

  // A pair occupies addr and addr+1; the base must be aligned and the top word must exist.
  function automatic bit rb_pair_ok(input int addr, input int num);
    return ((addr % RB_PAIR_ALIGN) == 0) && ((addr + 1) < num);
  endfunction

endpackage

// File: rtl/reg_bank_rdport.sv
// One combinational read port: range check, write-first bypass, optional zero register 0.
// R0_ZERO_EN defined: address 0 always reads as zero.
module reg_bank_rdport
  import reg_bank_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs,
  input  logic [ADDR_WIDTH-1:0]               rd_addr,
  input  logic                                byp_lo_en,
  input  logic [ADDR_WIDTH-1:0]               byp_lo_addr,
  input  logic [DATA_WIDTH-1:0]               byp_lo_data,
  input  logic                                byp_hi_en,
  input  logic [ADDR_WIDTH-1:0]               byp_hi_addr,
  input  logic [DATA_WIDTH-1:0]               byp_hi_data,
  output logic [DATA_WIDTH-1:0]               rd_data
);

  always_comb begin
    rd_data = '0;
    if (int'(rd_addr) < NUM_REGS) begin
      rd_data = regs[rd_addr];
      if (byp_lo_en && (byp_lo_addr == rd_addr)) rd_data = byp_lo_data;
      if (byp_hi_en && (byp_hi_addr == rd_addr)) rd_data = byp_hi_data;
    end
`ifdef R0_ZERO_EN
    if (rd_addr == '0) rd_data = '0;
`else
`endif
  end

endmodule

// File: rtl/reg_bank.sv
// Parametrised register bank: single/pair write, two bypassed read ports, sync flush.
// R0_ZERO_EN defined: register 0 is hard-wired to zero and writes to it are dropped.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter int                    ADDR_WIDTH = $clog2(NUM_REGS),
  parameter logic [DATA_WIDTH-1:0] INIT       = '0
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic                  wr_pair,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_data_hi,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  wr_err
);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] mem;
  logic                                wr_ok;
  logic                                wr_acc;
  logic                                lo_we;
  logic                                hi_we;
  logic [ADDR_WIDTH-1:0]               hi_addr;

  assign hi_addr = wr_addr + ADDR_WIDTH'(1);

  always_comb begin
    wr_ok  = wr_pair ? rb_pair_ok(int'(wr_addr), NUM_REGS) : (int'(wr_addr) < NUM_REGS);
    // reset and flush both suppress the write, so the bypass must not show it either
    wr_acc = wr_en && wr_ok && !flush && clear_n;
    hi_we  = wr_acc && wr_pair;
    lo_we  = wr_acc;
`ifdef R0_ZERO_EN
    if (wr_addr == '0) lo_we = 1'b0;
`else
`endif
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      mem    <= {NUM_REGS{INIT}};
      wr_err <= 1'b0;
    end else if (flush) begin
      mem    <= '0;
      wr_err <= 1'b0;
    end else if (wr_en) begin
      wr_err <= !wr_ok;
      if (lo_we) mem[wr_addr] <= wr_data;
      if (hi_we) mem[hi_addr] <= wr_data_hi;
    end
  end

  reg_bank_rdport #(
    .DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS), .ADDR_WIDTH(ADDR_WIDTH)
  ) u_rd_a (
    .regs(mem), .rd_addr(rd_addr_a),
    .byp_lo_en(lo_we), .byp_lo_addr(wr_addr), .byp_lo_data(wr_data),
    .byp_hi_en(hi_we), .byp_hi_addr(hi_addr), .byp_hi_data(wr_data_hi),
    .rd_data(rd_data_a)
  );

  reg_bank_rdport #(
    .DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS), .ADDR_WIDTH(ADDR_WIDTH)
  ) u_rd_b (
    .regs(mem), .rd_addr(rd_addr_b),
    .byp_lo_en(lo_we), .byp_lo_addr(wr_addr), .byp_lo_data(wr_data),
    .byp_hi_en(hi_we), .byp_hi_addr(hi_addr), .byp_hi_data(wr_data_hi),
    .rd_data(rd_data_b)
  );

endmodule

// File: tb/tb_reg_bank.sv
// Directed self-checking bench for reg_bank (NUM_REGS=12, INIT=A5A5_A5A5).
module tb_reg_bank;

  localparam int          DW   = 32;
  localparam int          NR   = 12;
  localparam int          AW   = 4;
  localparam logic [31:0] INIT = 32'hA5A5_A5A5;

  logic          clock = 1'b0;
  logic          clear_n, flush, wr_en, wr_pair;
  logic [AW-1:0] wr_addr, rd_addr_a, rd_addr_b;
  logic [DW-1:0] wr_data, wr_data_hi, rd_data_a, rd_data_b;
  logic          wr_err;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  reg_bank #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .INIT(INIT)) dut (
    .clock(clock), .clear_n(clear_n), .flush(flush), .wr_en(wr_en), .wr_pair(wr_pair),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_data_hi(wr_data_hi),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .wr_err(wr_err)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic read_ab(input int a, input int b, input logic [DW-1:0] ea,
                         input logic [DW-1:0] eb, input string tag);
    rd_addr_a = AW'(a);
    rd_addr_b = AW'(b);
    #1;
    check({tag, "_a"}, rd_data_a, ea);
    check({tag, "_b"}, rd_data_b, eb);
  endtask

  task automatic idle();
    wr_en = 0; wr_pair = 0; flush = 0;
  endtask

  logic [DW-1:0] r0_exp;

  initial begin
`ifdef R0_ZERO_EN
    r0_exp = '0;
`else
    r0_exp = INIT;
`endif
    clear_n = 0; idle(); wr_addr = 0; wr_data = 0; wr_data_hi = 0;
    rd_addr_a = 0; rd_addr_b = 0;
    repeat (2) @(posedge clock);
    @(negedge clock); clear_n = 1;
    #1;

    // reset contents on both ports
    check("rst_err", {31'd0, wr_err}, 32'd0);
    for (int i = 0; i < NR; i++)
      read_ab(i, NR - 1 - i, (i == 0) ? r0_exp : INIT, (i == NR - 1) ? r0_exp : INIT, "rst");
    read_ab(13, 15, 32'd0, 32'd0, "rst_oor");

    // single write with same-cycle bypass
    wr_en = 1; wr_addr = 5; wr_data = 32'h1234;
    read_ab(5, 4, 32'h1234, INIT, "wr5_byp");
    tick(); idle();
    read_ab(5, 4, 32'h1234, INIT, "wr5");
    check("wr5_err", {31'd0, wr_err}, 32'd0);

    // valid pair write, bypass on both words
    wr_en = 1; wr_pair = 1; wr_addr = 6; wr_data = 32'h1111; wr_data_hi = 32'h2222;
    read_ab(7, 6, 32'h2222, 32'h1111, "pair6_byp");
    tick(); idle();
    read_ab(6, 7, 32'h1111, 32'h2222, "pair6");

    // misaligned pair: nothing written, no bypass
    wr_en = 1; wr_pair = 1; wr_addr = 7; wr_data = 32'hDEAD; wr_data_hi = 32'hBEEF;
    read_ab(7, 8, 32'h2222, INIT, "pair7_byp");
    tick(); idle();
    read_ab(7, 8, 32'h2222, INIT, "pair7");
    read_ab(6, 5, 32'h1111, 32'h1234, "pair7_keep");
    check("pair7_err", {31'd0, wr_err}, 32'd1);
    tick();
    check("err_hold", {31'd0, wr_err}, 32'd1);

    // accepted write clears the error
    wr_en = 1; wr_addr = 2; wr_data = 32'h55;
    tick(); idle();
    check("wr2_err", {31'd0, wr_err}, 32'd0);
    read_ab(2, 3, 32'h55, INIT, "wr2");

    // pair at top of bank is valid; pair at 12 would need 13 and is rejected
    wr_en = 1; wr_pair = 1; wr_addr = 10; wr_data = 32'hA0A0; wr_data_hi = 32'hB1B1;
    tick(); idle();
    read_ab(10, 11, 32'hA0A0, 32'hB1B1, "pair10");
    check("pair10_err", {31'd0, wr_err}, 32'd0);
    wr_en = 1; wr_pair = 1; wr_addr = 12; wr_data = 32'hC0C0; wr_data_hi = 32'hD1D1;
    tick(); idle();
    check("pair12_err", {31'd0, wr_err}, 32'd1);
    read_ab(0, 11, r0_exp, 32'hB1B1, "pair12_nowrap");

    // single write out of range
    wr_en = 1; wr_addr = 13; wr_data = 32'h7777;
    read_ab(13, 1, 32'd0, INIT, "wr13_byp");
    tick(); idle();
    check("wr13_err", {31'd0, wr_err}, 32'd1);
    read_ab(13, 1, 32'd0, INIT, "wr13");

    // flush beats write; no bypass during flush
    flush = 1; wr_en = 1; wr_addr = 3; wr_data = 32'h77;
    read_ab(3, 5, INIT, 32'h1234, "flush_byp");
    tick(); idle();
    check("flush_err", {31'd0, wr_err}, 32'd0);
    for (int i = 0; i < NR; i += 2)
      read_ab(i, i + 1, 32'd0, 32'd0, "flush");

    // reset asserted between edges while a write is pending
    wr_en = 1; wr_addr = 4; wr_data = 32'hABCD;
    tick(); idle();
    read_ab(4, 9, 32'hABCD, 32'd0, "pre_rst");
    wr_en = 1; wr_addr = 9; wr_data = 32'h9999; wr_pair = 0;
    #2 clear_n = 0;
    read_ab(9, 4, INIT, INIT, "mid_rst");
    tick();
    read_ab(9, 4, INIT, INIT, "rst_hold");
    check("mid_rst_err", {31'd0, wr_err}, 32'd0);
    idle();
    @(negedge clock); clear_n = 1;
    #1;

`ifdef R0_ZERO_EN
    wr_en = 1; wr_addr = 0; wr_data = 32'hFFFF;
    read_ab(0, 1, 32'd0, INIT, "r0_byp");
    tick(); idle();
    read_ab(0, 1, 32'd0, INIT, "r0");
    check("r0_err", {31'd0, wr_err}, 32'd0);
    wr_en = 1; wr_pair = 1; wr_addr = 0; wr_data = 32'h1; wr_data_hi = 32'h2;
    read_ab(0, 1, 32'd0, 32'h2, "r0_pair_byp");
    tick(); idle();
    read_ab(0, 1, 32'd0, 32'h2, "r0_pair");
    check("r0_pair_err", {31'd0, wr_err}, 32'd0);
`else
    wr_en = 1; wr_addr = 0; wr_data = 32'hFFFF;
    tick(); idle();
    read_ab(0, 1, 32'hFFFF, INIT, "r0_plain");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
